// File: rtl/simd_pkg.sv
// Shared defaults and types for the SIMD result path.
// Both the drain controller and the row serializer import these.
package simd_pkg;

    localparam int PE_COUNT_DEFAULT   = 4;
    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int ADDR_WIDTH_DEFAULT = 10;
    localparam int RD_LATENCY_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SEND,
        FIN
    } drain_state_t;

    // Lane index width; never zero so a single-lane build still has a counter.
    function automatic int lane_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_serializer.sv
// Holds one result row and streams its lanes out, one word per handshake.
// The word and the last flag stay stable while the consumer stalls.
module row_serializer
    import simd_pkg::*;
#(
    parameter int PE_COUNT   = PE_COUNT_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic                           last_row,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] row_data,
    input  logic                           m_tready,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic                           m_tvalid,
    output logic                           m_tlast,
    output logic                           row_done
);

    localparam int LW = lane_bits(PE_COUNT);
    localparam logic [LW-1:0] LAST_LANE = LW'(PE_COUNT - 1);

    logic [DATA_WIDTH-1:0] row_q [PE_COUNT];
    logic [LW-1:0]         lane_q;
    logic                  active_q;
    logic                  last_row_q;
    logic                  handshake;
    logic                  at_last_lane;

    assign at_last_lane = (lane_q == LAST_LANE);
    assign handshake    = active_q && m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PE_COUNT; i++) begin
                row_q[i] <= '0;
            end
            lane_q     <= '0;
            active_q   <= 1'b0;
            last_row_q <= 1'b0;
        end else if (load) begin
            for (int unsigned i = 0; i < PE_COUNT; i++) begin
                row_q[i] <= row_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            lane_q     <= '0;
            active_q   <= 1'b1;
            last_row_q <= last_row;
        end else if (handshake) begin
            if (at_last_lane) begin
                lane_q   <= '0;
                active_q <= 1'b0;
            end else begin
                lane_q <= lane_q + 1'b1;
            end
        end
    end

    assign m_tvalid = active_q;
    assign m_tdata  = active_q ? row_q[lane_q] : '0;
    assign m_tlast  = active_q && last_row_q && at_last_lane;
    assign row_done = handshake && at_last_lane;

endmodule

// File: rtl/result_drain.sv
// Drains a block of result rows from the result BRAM to the PS stream.
// Controller owns the FSM, the read address and the remaining-row count.
module result_drain
    import simd_pkg::*;
#(
    parameter int PE_COUNT   = PE_COUNT_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int RD_LATENCY = RD_LATENCY_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            row_count,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_WIDTH-1:0]          bram_r_r_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           m_tlast
);

    localparam int WCW = $clog2(RD_LATENCY + 1) + 1;
    localparam logic [ADDR_WIDTH:0] ONE_ROW = (ADDR_WIDTH + 1)'(1);

    drain_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rows_q, rows_d;
    logic [WCW-1:0]        wait_q, wait_d;
    logic                  load;
    logic                  row_done;
    logic                  last_row;

    assign last_row      = (rows_q == ONE_ROW);
    assign bram_r_r_addr = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rows_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rows_q  <= rows_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rows_d  = rows_q;
        wait_d  = wait_q;
        load    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d = row_count;
                    // An empty drain must not disturb the read address.
                    if (row_count == '0) begin
                        state_d = FIN;
                    end else begin
                        addr_d  = base_addr;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                busy    = 1'b1;
                wait_d  = WCW'(1);
                state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_q == WCW'(RD_LATENCY)) begin
                    load    = 1'b1;
                    wait_d  = '0;
                    state_d = SEND;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (row_done) begin
                    rows_d = rows_q - 1'b1;
                    if (last_row) begin
                        state_d = FIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    row_serializer #(
        .PE_COUNT  (PE_COUNT),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_row_serializer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .last_row(last_row),
        .row_data(bram_r_r_data),
        .m_tready(m_tready),
        .m_tdata (m_tdata),
        .m_tvalid(m_tvalid),
        .m_tlast (m_tlast),
        .row_done(row_done)
    );

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain with a 2-cycle BRAM read model.
// Expected words and timing are written out by hand below.
module tb_result_drain;

    localparam int PE = 4;
    localparam int DW = 32;
    localparam int AW = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [AW-1:0]      base_addr;
    logic [AW:0]        row_count;
    logic               busy;
    logic               done;
    logic [AW-1:0]      bram_r_r_addr;
    logic [PE*DW-1:0]   bram_r_r_data;
    logic [DW-1:0]      m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tlast;

    int vecs = 0;
    int miscmp = 0;

    logic [PE*DW-1:0] mem [1024];
    logic [PE*DW-1:0] d1, d2;

    int first_valid, done_cyc, done_cnt, last_cyc, busy_at_done;
    int busy_ever, valid_ever, stable_bad;
    logic [DW-1:0] words[$];
    logic          lasts[$];
    logic [AW-1:0] addrs[$];

    int exp_a[12] = '{1, -2, 3, -4, 5, 6, 7, 8, -9, 10, 11, 12};
    int exp_w[8]  = '{100, 200, 300, 400, 1, -2, 3, -4};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1 <= mem[bram_r_r_addr];
        d2 <= d1;
    end
    assign bram_r_r_data = d2;

    result_drain #(
        .PE_COUNT  (PE),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_LATENCY(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .row_count    (row_count),
        .busy         (busy),
        .done         (done),
        .bram_r_r_addr(bram_r_r_addr),
        .bram_r_r_data(bram_r_r_data),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast)
    );

    function automatic logic [PE*DW-1:0] mkrow(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one drain from cycle 0 (start already high) and records what the stream did.
    task automatic collect(input int pat, input int max_cyc, input int stop_words, input int restart_cyc);
        int cyc;
        logic [DW-1:0] prev_d;
        bit stalled;
        words.delete(); lasts.delete(); addrs.delete();
        first_valid = -1; done_cyc = -1; done_cnt = 0; last_cyc = -1; busy_at_done = -1;
        busy_ever = 0; valid_ever = 0; stable_bad = 0;
        cyc = 0; stalled = 0; prev_d = '0;
        while (cyc < max_cyc) begin
            if (cyc == 1) start = 1'b0;
            if (cyc == restart_cyc) begin
                start = 1'b1; base_addr = 10'd2; row_count = 11'd1;
            end
            if (restart_cyc > 0 && cyc == restart_cyc + 1) start = 1'b0;
            m_tready = (pat == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (busy === 1'b1) begin
                busy_ever = 1;
                if (addrs.size() == 0 || addrs[$] !== bram_r_r_addr) addrs.push_back(bram_r_r_addr);
            end
            if (m_tvalid === 1'b1) begin
                valid_ever = 1;
                if (first_valid < 0) first_valid = cyc;
            end
            if (stalled && (m_tvalid !== 1'b1 || m_tdata !== prev_d)) stable_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    busy_at_done = busy;
                end
            end
            if (m_tvalid === 1'b1 && m_tready) begin
                words.push_back(m_tdata);
                lasts.push_back(m_tlast);
                if (m_tlast === 1'b1) last_cyc = cyc;
            end
            stalled = (m_tvalid === 1'b1) && !m_tready;
            prev_d = m_tdata;
            tick();
            cyc++;
            if (stop_words > 0 && words.size() == stop_words) break;
            if (done_cyc >= 0 && cyc > done_cyc + 3) break;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   32'(busy),          32'd0);
        chk({tag, "_done"},   32'(done),          32'd0);
        chk({tag, "_tvalid"}, 32'(m_tvalid),      32'd0);
        chk({tag, "_tlast"},  32'(m_tlast),       32'd0);
        chk({tag, "_tdata"},  m_tdata,            32'd0);
        chk({tag, "_addr"},   32'(bram_r_r_addr), 32'd0);
    endtask

    task automatic chk_block3(input string tag);
        chk({tag, "_nwords"}, 32'(words.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s_w%0d", tag, i), (i < words.size()) ? words[i] : 32'hdead_beef, 32'(exp_a[i]));
            chk($sformatf("%s_last%0d", tag, i), (i < lasts.size()) ? 32'(lasts[i]) : 32'hff, (i == 11) ? 32'd1 : 32'd0);
        end
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0]    = mkrow(1, -2, 3, -4);
        mem[1]    = mkrow(5, 6, 7, 8);
        mem[2]    = mkrow(-9, 10, 11, 12);
        mem[1023] = mkrow(100, 200, 300, 400);
        rst = 1'b1; start = 1'b0; base_addr = '0; row_count = '0; m_tready = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Three rows, consumer always ready.
        start = 1'b1; base_addr = 10'd0; row_count = 11'd3;
        chk("t1_busy_c0", 32'(busy), 32'd0);
        collect(0, 60, 0, -1);
        chk_block3("t1");
        chk("t1_first_valid", 32'(first_valid), 32'd4);
        chk("t1_last_cyc", 32'(last_cyc), 32'd21);
        chk("t1_done_cyc", 32'(done_cyc), 32'd22);
        chk("t1_busy_at_done", 32'(busy_at_done), 32'd0);
        tick();

        // Same block, ready toggling every cycle.
        start = 1'b1; base_addr = 10'd0; row_count = 11'd3;
        collect(1, 100, 0, -1);
        chk_block3("t2");
        chk("t2_stable", 32'(stable_bad), 32'd0);
        chk("t2_first_valid", 32'(first_valid), 32'd4);
        tick();

        // Address wrap from 1023 to 0.
        start = 1'b1; base_addr = 10'd1023; row_count = 11'd2;
        collect(0, 60, 0, -1);
        chk("t3_nwords", 32'(words.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_w%0d", i), (i < words.size()) ? words[i] : 32'hdead_beef, 32'(exp_w[i]));
        end
        chk("t3_last7", (lasts.size() == 8) ? 32'(lasts[7]) : 32'hff, 32'd1);
        chk("t3_naddr", 32'(addrs.size()), 32'd2);
        chk("t3_addr0", (addrs.size() > 0) ? 32'(addrs[0]) : 32'hffff, 32'd1023);
        chk("t3_addr1", (addrs.size() > 1) ? 32'(addrs[1]) : 32'hffff, 32'd0);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);
        tick();

        // Empty drain: done in cycle 1, nothing else moves.
        start = 1'b1; base_addr = 10'd5; row_count = 11'd0;
        collect(0, 10, 0, -1);
        chk("t4_done_cyc", 32'(done_cyc), 32'd1);
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        chk("t4_valid_ever", 32'(valid_ever), 32'd0);
        chk("t4_busy_ever", 32'(busy_ever), 32'd0);
        chk("t4_addr", 32'(bram_r_r_addr), 32'd0);
        tick();

        // Abort after six words, then a fresh one-row drain.
        start = 1'b1; base_addr = 10'd0; row_count = 11'd3;
        collect(0, 40, 6, -1);
        chk("t5_nwords_pre", 32'(words.size()), 32'd6);
        chk("t5_valid_pre", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_outputs("t5_rst");
        rst = 1'b0;
        m_tready = 1'b1;
        repeat (6) tick();
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_valid", 32'(m_tvalid), 32'd0);
        start = 1'b1; base_addr = 10'd0; row_count = 11'd1;
        collect(0, 30, 0, -1);
        chk("t5_nwords", 32'(words.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_w%0d", i), (i < words.size()) ? words[i] : 32'hdead_beef, 32'(exp_a[i]));
        end
        chk("t5_last3", (lasts.size() == 4) ? 32'(lasts[3]) : 32'hff, 32'd1);
        chk("t5_done_cyc", 32'(done_cyc), 32'd8);
        tick();

        // Second start mid-drain must be ignored.
        start = 1'b1; base_addr = 10'd0; row_count = 11'd3;
        collect(0, 60, 0, 6);
        chk_block3("t6");
        chk("t6_done_cyc", 32'(done_cyc), 32'd22);
        chk("t6_busy_after", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameter PE_COUNT, default 4, number of SIMD lanes per result row.
REQ-002 Parameter DATA_WIDTH, default 32, bits per lane word.
REQ-003 Parameter ADDR_WIDTH, default 10, result BRAM address width (depth 1024).
REQ-004 Parameter RD_LATENCY, default 2, result BRAM read latency in cycles.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  single-cycle request to drain a block of result rows.
REQ-008 base_addr  in  ADDR_WIDTH  first result row address, sampled with start.
REQ-009 row_count  in  ADDR_WIDTH+1  number of rows to drain (0..1024), sampled with start.
REQ-010 busy  out  1  drain in progress.
REQ-011 done  out  1  one-cycle pulse at drain completion.
REQ-012 bram_r_r_addr  out  ADDR_WIDTH  result BRAM read address, registered.
REQ-013 bram_r_r_data  in  PE_COUNT*DATA_WIDTH  result row; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 m_tdata  out  DATA_WIDTH  stream word to PS.
REQ-015 m_tvalid  out  1  stream word valid.
REQ-016 m_tready  in  1  PS accepts word.
REQ-017 m_tlast  out  1  marks final word of the drain.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, SEND, FIN; SHALL leave IDLE only on start.
REQ-019 start sampled in IDLE (cycle 0) SHALL latch base_addr/row_count, drive bram_r_r_addr=base_addr from cycle 1, raise busy from cycle 1.
REQ-020 start while not IDLE SHALL be ignored; latched parameters unchanged.
REQ-021 WAIT SHALL count RD_LATENCY cycles after the address is presented, then load the full row into a PE_COUNT-word row buffer.
REQ-022 SEND SHALL present row buffer lanes in order 0..PE_COUNT-1, one word per m_tvalid&&m_tready handshake.
REQ-023 m_tvalid SHALL first assert in cycle 1+RD_LATENCY+1 after start (cycle 4 for defaults).
REQ-024 Once m_tvalid is high, m_tdata and m_tlast SHALL hold stable and m_tvalid SHALL stay high until handshake.
REQ-025 m_tvalid low SHALL keep m_tdata at zero.
REQ-026 After the last lane handshake of a row, if rows remain, FSM SHALL go to ISSUE with bram_r_r_addr incremented by 1, modulo 2^ADDR_WIDTH (1023 wraps to 0).
REQ-027 m_tlast SHALL be high only on lane PE_COUNT-1 of the final row.
REQ-028 After the m_tlast handshake, FSM SHALL enter FIN: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
REQ-029 row_count=0 SHALL go IDLE->FIN directly: done pulses in cycle 1, no BRAM address change, no stream words.
REQ-030 Total words per drain SHALL equal row_count*PE_COUNT; no word dropped or duplicated under any m_tready pattern.
REQ-031 m_tready held low SHALL stall indefinitely with no BRAM read and no state change.

Reset
REQ-032 rst high at a clock edge SHALL force IDLE regardless of state, including mid-row.
REQ-033 Reset values: busy=0, done=0, m_tvalid=0, m_tlast=0, m_tdata=0, bram_r_r_addr=0, row buffer and counters=0.
REQ-034 An aborted drain SHALL not resume; a new start after rst release begins a fresh drain.

Structure
REQ-035 Shared package simd_pkg SHALL hold PE_COUNT, DATA_WIDTH, ADDR_WIDTH, RD_LATENCY defaults and the drain state enum type.
REQ-036 Row serialization (row buffer, lane counter, valid/last/data hold) SHALL be a sub-module row_serializer; FSM, address and row counters stay in result_drain.

Verification
REQ-037 Preload rows 0..2 with lane values {1,-2,3,-4},{5,6,7,8},{-9,10,11,12}; start base=0 count=3, tready=1 -> 12 words in order 1,-2,3,-4,5..., tlast only on word 12 (value 12), first tvalid cycle 4, done one cycle after it.
REQ-038 Same data, tready toggling 1-0-1-0 -> identical 12-word sequence, tdata stable across every stalled cycle.
REQ-039 start base=1023 count=2 -> bram_r_r_addr 1023 then 0; words of row 1023 then row 0.
REQ-040 start count=0 -> done pulses cycle 1, m_tvalid never asserts, busy never asserts.
REQ-041 rst asserted after word 6 of a 3-row drain -> next cycle all outputs at reset values; new start base=0 count=1 yields 1,-2,3,-4 with tlast on -4.
REQ-042 Second start pulsed during an active drain -> ignored; word count and done count unchanged.
